dl_rshift_iter: RTL

Iterative, handshaked right shifter: the right-direction counterpart to the design library's single-cycle left shifter. It performs a logical or arithmetic right shift of a `NUM_BITS` operand. It resolves one bit of the shift amount per cycle, as a log-stage shifter folded in time. It sits in the design library for area-constrained execute units (for example, a compact RISC-V SRL/SRA path) where a full barrel shifter is not affordable.

---
 rtl/dl_pkg.sv | 13 +
 rtl/dl_rshift_stage.sv | 33 +++
 rtl/dl_rshift_iter.sv | 109 ++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
// Shared design-library package.
// Holds the control-state encoding used by the iterative datapath blocks
// (IDLE -> SHIFT -> DONE), so every multi-cycle unit decodes its state the
// same way.
package dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } iter_state_e;

endpackage

// File: rtl/dl_rshift_stage.sv
// dl_rshift_stage: combinational right shift by a runtime power of two.
//   din  : value to shift
//   idx  : stage index; the shift distance is 2**idx
//   en   : 1 = apply the shift, 0 = pass din through unchanged
//   fill : bit written into the vacated MSBs
//   dout : shifted (or passed-through) value
module dl_rshift_stage #(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]       din,
  input  logic [NUM_SHIFT_BITS-1:0] idx,
  input  logic                      en,
  input  logic                      fill,
  output logic [NUM_BITS-1:0]       dout
);

  logic [NUM_SHIFT_BITS-1:0] amt;
  logic [NUM_BITS-1:0]       fill_mask;

  always_comb begin
    // 2**idx always fits: the largest stage shifts by NUM_BITS/2.
    amt       = NUM_SHIFT_BITS'(1) << idx;
    // Ones in exactly the MSB positions vacated by the shift.
    fill_mask = ~({NUM_BITS{1'b1}} >> amt);
    if (en) begin
      dout = (din >> amt) | (fill ? fill_mask : '0);
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/dl_rshift_iter.sv
// dl_rshift_iter: iterative, handshaked logical/arithmetic right shifter.
// One bit of the shift amount is resolved per cycle (a log-stage shifter
// folded in time), so latency is fixed at NUM_SHIFT_BITS cycles after
// acceptance regardless of the shift value.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_val / in_rdy   : request handshake (in_rdy registered)
//   a, shift, arith   : operand, shift amount, 1 = sign fill / 0 = zero fill
//   out_val / out_rdy : result handshake (out_val registered)
//   out               : registered result, stable throughout DONE
module dl_rshift_iter
  import dl_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [NUM_BITS-1:0]       a,
  input  logic [NUM_SHIFT_BITS-1:0] shift,
  input  logic                      arith,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [NUM_BITS-1:0]       out
);

  iter_state_e               state_q;
  logic [NUM_SHIFT_BITS-1:0] cnt_q;
  logic [NUM_BITS-1:0]       opnd_q;
  logic [NUM_SHIFT_BITS-1:0] shamt_q;
  logic                      arith_q;
  logic                      sign_q;
  logic [NUM_BITS-1:0]       res_q;

  logic [NUM_BITS-1:0]       stage_din;
  logic [NUM_BITS-1:0]       stage_dout;
  logic                      last_stage;

  // Stage 0 reads the captured operand; later stages read the running
  // result. This keeps `out` untouched until the first SHIFT edge.
  assign stage_din  = (cnt_q == '0) ? opnd_q : res_q;
  assign last_stage = (cnt_q == NUM_SHIFT_BITS'(NUM_SHIFT_BITS - 1));

  dl_rshift_stage #(
    .NUM_BITS (NUM_BITS)
  ) u_stage (
    .din  (stage_din),
    .idx  (cnt_q),
    .en   (shamt_q[cnt_q]),
    // Fill comes from the operand MSB captured at acceptance.
    .fill (arith_q & sign_q),
    .dout (stage_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_val) begin
            opnd_q  <= a;
            shamt_q <= shift;
            arith_q <= arith;
            sign_q  <= a[NUM_BITS-1];
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
            in_rdy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          res_q <= stage_dout;
          if (last_stage) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
            out_val <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_rdy) begin
            state_q <= ST_IDLE;
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          in_rdy  <= 1'b1;
          out_val <= 1'b0;
        end
      endcase
    end
  end

  assign out = res_q;

endmodule
